// File: rtl/zebra_frame_scheduler_if.sv
// Frame-buffer read port and zebra_crossing_detector pixel/result port.
// The scheduler is the master side; buffer and detector sit on the slave side.
interface zebra_frame_scheduler_if #(
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 19
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_rd_data;

    logic              det_pixel_valid;
    logic [W-1:0]      det_edge_pixel;
    logic              det_detection_valid;
    logic              det_crossing_detected;
    logic [7:0]        det_stripe_count;
    logic [15:0]       det_confidence;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output det_pixel_valid,
        output det_edge_pixel,
        input  det_detection_valid,
        input  det_crossing_detected,
        input  det_stripe_count,
        input  det_confidence
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  det_pixel_valid,
        input  det_edge_pixel,
        output det_detection_valid,
        output det_crossing_detected,
        output det_stripe_count,
        output det_confidence
    );
endinterface

// File: rtl/zebra_frame_scheduler.sv
// Streams one edge-image frame from the frame buffer into the zebra crossing
// detector, waits (with timeout) for its verdict and reports frame completion.
module zebra_frame_scheduler #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned W          = 8,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [15:0] frame_count,
    output logic        result_crossing,
    output logic [7:0]  result_stripes,
    output logic [15:0] result_confidence,
    zebra_frame_scheduler_if.master bus
);
    localparam int unsigned PIX_N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                rd_en_q;
    logic                pix_valid_q;
    logic                done_d;
    logic                terr_d;
    logic [15:0]         fcnt_d;
    logic                res_cross_d;
    logic [7:0]          res_stripes_d;
    logic [15:0]         res_conf_d;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        tcnt_d        = tcnt_q;
        done_d        = 1'b0;
        terr_d        = timeout_err;
        fcnt_d        = frame_count;
        res_cross_d   = result_crossing;
        res_stripes_d = result_stripes;
        res_conf_d    = result_confidence;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (addr_q == LAST_ADDR) state_d = S_DRAIN;
                else                     addr_d  = addr_q + ADDR_W'(1);
            end
            S_DRAIN: begin
                state_d = S_WAIT;
                tcnt_d  = '0;
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                // A detection on the expiry cycle wins over the timeout
                if (bus.det_detection_valid) begin
                    state_d = S_DONE;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = continuous ? S_STREAM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.det_detection_valid && (state_q inside {S_STREAM, S_DRAIN, S_WAIT})) begin
            res_cross_d   = bus.det_crossing_detected;
            res_stripes_d = bus.det_stripe_count;
            res_conf_d    = bus.det_confidence;
        end

        // Abort beats everything; address and error flag stay where they were
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            terr_d  = timeout_err;
        end

        if ((state_d == S_STREAM) && (state_q != S_STREAM)) begin
            addr_d        = '0;
            terr_d        = 1'b0;
            res_cross_d   = 1'b0;
            res_stripes_d = '0;
            res_conf_d    = '0;
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
            fcnt_d = frame_count + 16'd1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            addr_q            <= '0;
            tcnt_q            <= '0;
            rd_en_q           <= 1'b0;
            pix_valid_q       <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            timeout_err       <= 1'b0;
            frame_count       <= '0;
            result_crossing   <= 1'b0;
            result_stripes    <= '0;
            result_confidence <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            tcnt_q            <= tcnt_d;
            rd_en_q           <= (state_d == S_STREAM);
            pix_valid_q       <= rd_en_q;
            busy              <= (state_d != S_IDLE);
            done              <= done_d;
            timeout_err       <= terr_d;
            frame_count       <= fcnt_d;
            result_crossing   <= res_cross_d;
            result_stripes    <= res_stripes_d;
            result_confidence <= res_conf_d;
        end
    end

    // Read data arrives one cycle after the strobe, aligned with pix_valid_q
    assign bus.mem_rd_en       = rd_en_q;
    assign bus.mem_addr        = addr_q;
    assign bus.det_pixel_valid = pix_valid_q;
    assign bus.det_edge_pixel  = {W{pix_valid_q}} & bus.mem_rd_data;

endmodule

// File: tb/tb_zebra_frame_scheduler.sv
// Scoreboard bench for zebra_frame_scheduler: buffer returns data=addr, a small
// detector model answers a programmable number of cycles after the last pixel.
module tb_zebra_frame_scheduler;
    localparam int unsigned IW = 8;
    localparam int unsigned IH = 4;
    localparam int unsigned N  = IW * IH;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned TO = 10;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        continuous = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] frame_count;
    logic        result_crossing;
    logic [7:0]  result_stripes;
    logic [15:0] result_confidence;

    zebra_frame_scheduler_if #(.W(W), .ADDR_W(AW)) bus ();

    zebra_frame_scheduler #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .W         (W),
        .ADDR_W    (AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .continuous       (continuous),
        .busy             (busy),
        .done             (done),
        .timeout_err      (timeout_err),
        .frame_count      (frame_count),
        .result_crossing  (result_crossing),
        .result_stripes   (result_stripes),
        .result_confidence(result_confidence),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        crossing;
        logic [7:0]  stripes;
        logic [15:0] conf;
        logic        terr;
        logic [15:0] fc;
        int          delay;
    } done_t;

    logic [W-1:0] exp_pix[$];
    done_t        exp_done[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Frame buffer: data = address, one cycle read latency
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= W'(bus.mem_addr);
    end

    // Detector model: answers det_delay cycles after the last pixel (0 = never)
    int          det_delay = 0;
    int          det_cd    = 0;
    logic        det_x     = 1'b0;
    logic [7:0]  det_s     = '0;
    logic [15:0] det_c     = '0;

    always @(negedge clk) begin
        bus.det_detection_valid   = 1'b0;
        bus.det_crossing_detected = 1'b1;
        bus.det_stripe_count      = 8'hEE;
        bus.det_confidence        = 16'hDEAD;
        if (det_cd > 0) begin
            det_cd--;
            if (det_cd == 0) begin
                bus.det_detection_valid   = 1'b1;
                bus.det_crossing_detected = det_x;
                bus.det_stripe_count      = det_s;
                bus.det_confidence        = det_c;
            end
        end
        if (bus.det_pixel_valid && (bus.det_edge_pixel == W'(N - 1)) && (det_delay > 0))
            det_cd = det_delay;
    end

    // Monitor: pops expected pixels and frame completions as the DUT presents them
    logic [W-1:0] mon_p;
    done_t        mon_r;
    int           last_pix_cyc = 0;

    always @(negedge clk) begin
        if (bus.det_pixel_valid) begin
            if (exp_pix.size() == 0) begin
                fail_now("unexpected_pixel", 32'(bus.det_edge_pixel));
            end else begin
                mon_p = exp_pix.pop_front();
                chk("pixel_value", 32'(bus.det_edge_pixel), 32'(mon_p));
                if (mon_p != '0) chk("pixel_gap", 32'(cyc - last_pix_cyc), 32'd1);
                last_pix_cyc = cyc;
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                fail_now("unexpected_done", 32'(frame_count));
            end else begin
                mon_r = exp_done.pop_front();
                chk("done_crossing",   32'(result_crossing),   32'(mon_r.crossing));
                chk("done_stripes",    32'(result_stripes),    32'(mon_r.stripes));
                chk("done_confidence", 32'(result_confidence), 32'(mon_r.conf));
                chk("done_timeout_err", 32'(timeout_err),      32'(mon_r.terr));
                chk("done_frame_count", 32'(frame_count),      32'(mon_r.fc));
                chk("done_latency", 32'(cyc - last_pix_cyc),   32'(mon_r.delay));
            end
        end
    end

    task automatic push_frame(input int n_pix);
        for (int i = 0; i < n_pix; i++) exp_pix.push_back(W'(i));
    endtask

    task automatic push_done(input logic x, input logic [7:0] s, input logic [15:0] c,
                             input logic te, input logic [15:0] fc, input int dly);
        done_t r;
        r.crossing = x;
        r.stripes  = s;
        r.conf     = c;
        r.terr     = te;
        r.fc       = fc;
        r.delay    = dly;
        exp_done.push_back(r);
    endtask

    task automatic set_det(input int dly, input logic x, input logic [7:0] s, input logic [15:0] c);
        det_delay = dly;
        det_x     = x;
        det_s     = s;
        det_c     = c;
    endtask

    task automatic pulse_start(output int s_cyc);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({name, "_done_wait_expired"}, 32'(budget));
    endtask

    task automatic wait_pixel(input string name, input logic [W-1:0] v, input int budget);
        bit seen = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            if (bus.det_pixel_valid && (bus.det_edge_pixel == v)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({name, "_pixel_wait_expired"}, 32'(v));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},        32'(busy),                32'd0);
        chk({tag, "_done"},        32'(done),                32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err),         32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count),         32'd0);
        chk({tag, "_mem_rd_en"},   32'(bus.mem_rd_en),       32'd0);
        chk({tag, "_mem_addr"},    32'(bus.mem_addr),        32'd0);
        chk({tag, "_pix_valid"},   32'(bus.det_pixel_valid), 32'd0);
        chk({tag, "_edge_pixel"},  32'(bus.det_edge_pixel),  32'd0);
        chk({tag, "_res_cross"},   32'(result_crossing),     32'd0);
        chk({tag, "_res_stripes"}, 32'(result_stripes),      32'd0);
        chk({tag, "_res_conf"},    32'(result_confidence),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single frame, detector answers 3 cycles after the last pixel
        set_det(3, 1'b1, 8'd5, 16'd200);
        push_frame(N);
        push_done(1'b1, 8'd5, 16'd200, 1'b0, 16'd1, 4);
        pulse_start(s_cyc);
        wait_pixel("t1_first", W'(0), 10);
        chk("t1_first_pixel_latency", 32'(cyc - s_cyc), 32'd2);
        wait_done("t1", 200);
        @(negedge clk);
        chk("t1_busy_after_done", 32'(busy), 32'd0);
        chk("t1_addr_held", 32'(bus.mem_addr), 32'(N - 1));
        chk("t1_frame_count", 32'(frame_count), 32'd1);

        // 2: detector never answers -> timeout
        set_det(0, 1'b0, 8'd0, 16'd0);
        push_frame(N);
        push_done(1'b0, 8'd0, 16'd0, 1'b1, 16'd2, TO + 1);
        pulse_start(s_cyc);
        wait_done("t2", 200);
        @(negedge clk);
        chk("t2_timeout_err_held", 32'(timeout_err), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);

        // 3: continuous, three frames, continuous dropped during the third
        set_det(3, 1'b0, 8'd3, 16'd77);
        for (int f = 0; f < 3; f++) begin
            push_frame(N);
            push_done(1'b0, 8'd3, 16'd77, 1'b0, 16'(3 + f), 4);
        end
        continuous = 1'b1;
        pulse_start(s_cyc);
        chk("t3_timeout_err_cleared", 32'(timeout_err), 32'd0);
        wait_done("t3_f1", 200);
        wait_done("t3_f2", 200);
        repeat (5) @(negedge clk);
        continuous = 1'b0;
        wait_done("t3_f3", 200);
        @(negedge clk);
        chk("t3_busy_after_last", 32'(busy), 32'd0);
        chk("t3_frame_count", 32'(frame_count), 32'd5);

        // 4: abort at pixel 12; one residual pixel (13) allowed
        set_det(3, 1'b0, 8'd3, 16'd77);
        push_frame(14);
        pulse_start(s_cyc);
        wait_pixel("t4_p12", W'(12), 50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("t4_pix_valid_low", 32'(bus.det_pixel_valid), 32'd0);
        chk("t4_rd_en_low", 32'(bus.mem_rd_en), 32'd0);
        chk("t4_busy_low", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("t4_frame_count_kept", 32'(frame_count), 32'd5);
        chk("t4_pixels_consumed", 32'(exp_pix.size()), 32'd0);
        push_frame(N);
        push_done(1'b0, 8'd3, 16'd77, 1'b0, 16'd6, 4);
        pulse_start(s_cyc);
        chk("t4_restart_rd_en", 32'(bus.mem_rd_en), 32'd1);
        chk("t4_restart_addr", 32'(bus.mem_addr), 32'd0);
        wait_done("t4_restart", 200);

        // 5: detection on the expiry cycle, plus a start pulse during STREAM
        set_det(TO, 1'b1, 8'd9, 16'd1234);
        push_frame(N);
        push_done(1'b1, 8'd9, 16'd1234, 1'b0, 16'd7, TO + 1);
        pulse_start(s_cyc);
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", 200);
        @(negedge clk);
        chk("t5_timeout_err", 32'(timeout_err), 32'd0);
        chk("t5_res_conf_kept", 32'(result_confidence), 32'd1234);
        chk("t5_busy", 32'(busy), 32'd0);

        // 6: asynchronous reset at pixel 20
        set_det(3, 1'b1, 8'd1, 16'd1);
        push_frame(21);
        pulse_start(s_cyc);
        wait_pixel("t6_p20", W'(20), 60);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_zero("t6_async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy_after_release", 32'(busy), 32'd0);
        chk("t6_frame_count_after_release", 32'(frame_count), 32'd0);
        chk("t6_pix_valid_after_release", 32'(bus.det_pixel_valid), 32'd0);

        chk("end_pixels_left", 32'(exp_pix.size()), 32'd0);
        chk("end_dones_left", 32'(exp_done.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
